// File: rtl/fifo_drain_checker.sv
// fifo_drain_checker: pulls words from a FIFO and checks them
// against an LFSR data pattern, counting words and errors.
module fifo_drain_checker #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter logic [15:0] DATA_SEED = 16'h0001,
  parameter logic [15:0] THR_SEED  = 16'h70f0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 enable,
  input  logic                 throttle_en,
  input  logic [CNT_WIDTH-1:0] target,
  input  logic                 fifo_empty,
  input  logic [15:0]          read_data,
  input  logic                 rdata_valid,
  output logic                 read_req,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 mismatch,
  output logic [15:0]          first_err_data,
  output logic [15:0]          first_err_exp,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] ONE     = 1;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [15:0]          thr;
  logic [15:0]          exp_q;
  logic [CNT_WIDTH-1:0] issued;
  logic [CNT_WIDTH-1:0] outstanding;
  logic [CNT_WIDTH-1:0] issued_inc;
  logic [CNT_WIDTH-1:0] word_inc;
  logic [CNT_WIDTH-1:0] err_inc;
  logic                 at_target;
  logic                 reached;
  logic                 drained;
  logic                 thr_ok;
  logic                 unexp;
  logic                 bad;

  // Run-limit and drain conditions from registered counters.
  assign at_target   = (target != '0) && (issued == target);
  assign reached     = (target != '0) && (word_count >= target);
  assign outstanding = issued - word_count;
  assign drained     = (outstanding == '0);

  assign thr_ok = !throttle_en || thr[7] || thr[13];

  // Data with nothing outstanding is an error, not a word,
  // so issued - word_count never goes negative.
  assign unexp = rdata_valid && drained;
  assign bad   = rdata_valid
               && (unexp || (read_data != exp_q));

  assign read_req = (state == RUN)
                  && !fifo_empty
                  && thr_ok
                  && !at_target;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  // Saturating increments.
  always_comb begin
    issued_inc = issued;
    word_inc   = word_count;
    err_inc    = err_count;
    if (issued != CNT_MAX)
      issued_inc = issued + ONE;
    if (word_count != CNT_MAX)
      word_inc = word_count + ONE;
    if (err_count != CNT_MAX)
      err_inc = err_count + ONE;
  end

  // Next-state decode for the run sequencer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (enable)
          state_nxt = RUN;
      end
      RUN: begin
        if (!enable || at_target)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drained)
          state_nxt = reached ? DONE : IDLE;
      end
      DONE: begin
        if (!enable)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else if (flush)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Throttle LFSR free-runs every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      thr <= THR_SEED;
    else if (flush)
      thr <= THR_SEED;
    else
      thr <= {thr[14:0],
              ~(thr[15] ^ thr[14] ^ thr[12] ^ thr[3])};
  end

  // Expected-data LFSR steps once per returned word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      exp_q <= DATA_SEED;
    else if (flush)
      exp_q <= DATA_SEED;
    else if (rdata_valid)
      exp_q <= {exp_q[14:0], exp_q[15] ^ exp_q[14]};
  end

  // Requests issued since reset or flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      issued <= '0;
    else if (flush)
      issued <= '0;
    else if (read_req)
      issued <= issued_inc;
  end

  // Words received against an outstanding request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      word_count <= '0;
    else if (flush)
      word_count <= '0;
    else if (rdata_valid && !unexp)
      word_count <= word_inc;
  end

  // Mismatches and unexpected words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_count <= '0;
    else if (flush)
      err_count <= '0;
    else if (bad)
      err_count <= err_inc;
  end

  // Sticky flag plus capture of the first bad word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mismatch       <= 1'b0;
      first_err_data <= '0;
      first_err_exp  <= '0;
    end else if (flush) begin
      mismatch       <= 1'b0;
      first_err_data <= '0;
      first_err_exp  <= '0;
    end else if (bad && !mismatch) begin
      mismatch       <= 1'b1;
      first_err_data <= read_data;
      first_err_exp  <= exp_q;
    end
  end

endmodule

// File: tb/tb_fifo_drain_checker.sv
// tb_fifo_drain_checker: directed and random runs against a
// FIFO emulator and a cycle-level reference model.
module tb_fifo_drain_checker;

  localparam int W    = 16;
  localparam int CMAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          flush = 1'b0;
  logic          enable = 1'b0;
  logic          throttle_en = 1'b0;
  logic [W-1:0]  target = '0;
  logic          fifo_empty = 1'b1;
  logic [15:0]   read_data = '0;
  logic          rdata_valid = 1'b0;
  logic          read_req;
  logic [W-1:0]  word_count;
  logic [W-1:0]  err_count;
  logic          mismatch;
  logic [15:0]   first_err_data;
  logic [15:0]   first_err_exp;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fifo_drain_checker #(
    .CNT_WIDTH(W),
    .DATA_SEED(16'h0001),
    .THR_SEED(16'h70f0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .enable(enable),
    .throttle_en(throttle_en),
    .target(target),
    .fifo_empty(fifo_empty),
    .read_data(read_data),
    .rdata_valid(rdata_valid),
    .read_req(read_req),
    .word_count(word_count),
    .err_count(err_count),
    .mismatch(mismatch),
    .first_err_data(first_err_data),
    .first_err_exp(first_err_exp),
    .busy(busy),
    .done(done)
  );

  int nasrt = 0;
  int nfail = 0;

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done.
  int          m_ph;
  logic [15:0] m_thr;
  logic [15:0] m_exp;
  logic [15:0] m_fd;
  logic [15:0] m_fe;
  int          m_iss;
  int          m_wc;
  int          m_ec;
  bit          m_mm;
  bit          m_rr;

  // FIFO emulator.
  typedef struct {
    logic [15:0] d;
    int          due;
  } pend_t;

  logic [15:0] fq[$];
  pend_t       pq[$];
  int          cyc = 0;
  int          last_due = 0;
  int          fixed_lat = 0;
  logic [15:0] gen = 16'h0001;
  bit          rr_obs;
  int          rr_cnt = 0;
  int          rv_cnt = 0;

  function automatic logic [15:0] nthr(logic [15:0] t);
    return {t[14:0], ~(t[15] ^ t[14] ^ t[12] ^ t[3])};
  endfunction

  function automatic logic [15:0] nexp(logic [15:0] e);
    return {e[14:0], e[15] ^ e[14]};
  endfunction

  function automatic int sat(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] expv);
    nasrt++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, expv);
    end
  endtask

  task automatic m_reset();
    m_ph  = 0;
    m_thr = 16'h70f0;
    m_exp = 16'h0001;
    m_iss = 0;
    m_wc  = 0;
    m_ec  = 0;
    m_mm  = 0;
    m_fd  = '0;
    m_fe  = '0;
  endtask

  function automatic bit m_req();
    return (m_ph == 1) && !fifo_empty
        && (!throttle_en || m_thr[7] || m_thr[13])
        && !(target != 0 && m_iss == int'(target));
  endfunction

  task automatic m_step();
    int oi = m_iss;
    int ow = m_wc;
    bit un;
    bit er;
    if (!reset_n) begin
    end else if (flush) begin
      m_reset();
    end else begin
      un = rdata_valid && (oi == ow);
      er = rdata_valid && (un || read_data !== m_exp);
      if (er) begin
        m_ec = sat(m_ec + 1);
        if (!m_mm) begin
          m_mm = 1;
          m_fd = read_data;
          m_fe = m_exp;
        end
      end
      if (rdata_valid) begin
        if (!un) m_wc = sat(ow + 1);
        m_exp = nexp(m_exp);
      end
      if (m_rr) m_iss = sat(oi + 1);
      case (m_ph)
        0: if (enable) m_ph = 1;
        1: if (!enable || (target != 0 && oi == int'(target)))
             m_ph = 2;
        2: if (oi == ow)
             m_ph = (target != 0 && ow >= int'(target)) ? 3 : 0;
        default: if (!enable) m_ph = 0;
      endcase
      m_thr = nthr(m_thr);
    end
  endtask

  task automatic check_all();
    m_rr = m_req();
    chk("read_req", read_req, m_rr);
    chk("busy", busy, m_ph == 1 || m_ph == 2);
    chk("done", done, m_ph == 3);
    chk("word_count", word_count, m_wc);
    chk("err_count", err_count, m_ec);
    chk("mismatch", mismatch, m_mm);
    chk("first_err_data", first_err_data, m_fd);
    chk("first_err_exp", first_err_exp, m_fe);
  endtask

  task automatic ret();
    pend_t p;
    rdata_valid = 1'b0;
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      p = pq.pop_front();
      rdata_valid = 1'b1;
      read_data = p.d;
    end
  endtask

  task automatic tick();
    int lat;
    int due;
    @(negedge clk);
    check_all();
    rr_obs = read_req;
    if (read_req) rr_cnt++;
    if (rdata_valid) rv_cnt++;
    @(posedge clk);
    m_step();
    cyc++;
    if (rr_obs && fq.size() > 0) begin
      lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 3);
      due = cyc + lat - 1;
      if (due <= last_due) due = last_due + 1;
      pq.push_back('{fq.pop_front(), due});
      last_due = due;
    end
    #1;
    ret();
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic env_clear();
    fq.delete();
    pq.delete();
    last_due = cyc;
    rdata_valid = 1'b0;
    fifo_empty = 1'b1;
    gen = 16'h0001;
  endtask

  task automatic push_good(int n);
    repeat (n) begin
      fq.push_back(gen);
      gen = nexp(gen);
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic drain_idle(string tag);
    int k = 0;
    enable = 1'b0;
    while (m_ph != 0 && k < 200) begin
      tick();
      k++;
    end
    chk(tag, k < 200, 1);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    m_reset();
    env_clear();
    #1;
    check_all();
    chk("rst_busy", busy, 0);
    chk("rst_rr", read_req, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_mm", mismatch, 0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [15:0] d;

    // Power-up reset.
    do_reset();

    // Sixteen-word run to target.
    for (int i = 0; i < 15; i++)
      fq.push_back(16'h0001 << i);
    fq.push_back(16'h8001);
    fifo_empty = 1'b0;
    target = 16;
    enable = 1'b1;
    rr_cnt = 0;
    n = 0;
    while (m_ph != 3 && n < 300) begin
      tick();
      n++;
    end
    chk("r16_timeout", n < 300, 1);
    chk("r16_rr", rr_cnt, 16);
    chk("r16_wc", word_count, 16);
    chk("r16_ec", err_count, 0);
    chk("r16_done", done, 1);

    // Continue unlimited: two bad words.
    drain_idle("r16_idle");
    target = 0;
    fq.push_back(16'h0004);
    fq.push_back(16'h0005);
    fifo_empty = 1'b0;
    enable = 1'b1;
    n = 0;
    while (m_wc < 18 && n < 100) begin
      tick();
      n++;
    end
    chk("bad_timeout", n < 100, 1);
    drain_idle("bad_idle");
    chk("bad_ec", err_count, 2);
    chk("bad_mm", mismatch, 1);
    chk("bad_fd", first_err_data, 16'h0004);
    chk("bad_fe", first_err_exp, 16'h0003);

    // Unexpected word while nothing is outstanding.
    rdata_valid = 1'b1;
    read_data = 16'h0006;
    tick();
    chk("unexp_ec", err_count, 3);
    chk("unexp_wc", word_count, 18);
    chk("unexp_fd", first_err_data, 16'h0004);

    // Flush, then restart from the seed.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    env_clear();
    chk("fl_wc", word_count, 0);
    chk("fl_ec", err_count, 0);
    chk("fl_mm", mismatch, 0);
    chk("fl_fd", first_err_data, 0);
    chk("fl_fe", first_err_exp, 0);
    chk("fl_busy", busy, 0);
    chk("fl_done", done, 0);
    push_good(2);
    enable = 1'b1;
    n = 0;
    while (m_wc < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("fl_timeout", n < 100, 1);
    chk("fl_run_ec", err_count, 0);
    drain_idle("fl_idle");

    // Empty FIFO throughout a run.
    enable = 1'b1;
    rr_cnt = 0;
    repeat (20) tick();
    chk("empty_rr", rr_cnt, 0);
    chk("empty_wc", word_count, 2);
    drain_idle("empty_idle");

    // Drop enable with two requests outstanding.
    fixed_lat = 3;
    push_good(10);
    enable = 1'b1;
    n = 0;
    while ((m_iss - m_wc) != 2 && n < 50) begin
      tick();
      n++;
    end
    chk("dr_timeout", n < 50, 1);
    fq.delete();
    fifo_empty = 1'b1;
    enable = 1'b0;
    rv_cnt = 0;
    tick();
    chk("dr_rr", read_req, 0);
    chk("dr_busy", busy, 1);
    drain_idle("dr_idle");
    chk("dr_rv", rv_cnt, 2);
    chk("dr_wc", word_count, 4);
    chk("dr_ec", err_count, 0);
    fixed_lat = 0;

    // Asynchronous reset in the middle of a run.
    push_good(8);
    enable = 1'b1;
    repeat (4) tick();
    do_reset();
    push_good(3);
    n = 0;
    while (m_wc < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("rs_timeout", n < 100, 1);
    chk("rs_ec", err_count, 0);
    chk("rs_wc", word_count, 3);
    drain_idle("rs_idle");

    // Throttled reads from a fresh seed.
    do_reset();
    throttle_en = 1'b1;
    push_good(40);
    enable = 1'b1;
    repeat (60) tick();
    drain_idle("thr_idle");
    throttle_en = 1'b0;

    // Random traffic with corruption and flushes.
    for (int i = 0; i < 400; i++) begin
      tick();
      if ($urandom_range(0, 1) == 1 && fq.size() < 8) begin
        d = gen;
        gen = nexp(gen);
        if ($urandom_range(0, 7) == 0)
          d ^= 16'($urandom_range(1, 65535));
        fq.push_back(d);
        fifo_empty = 1'b0;
      end
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 29) == 0)
        throttle_en = ~throttle_en;
      if (m_ph == 0 && $urandom_range(0, 3) == 0)
        target = ($urandom_range(0, 1) == 1) ? '0
               : W'(m_iss + int'($urandom_range(0, 6)));
      if ($urandom_range(0, 149) == 0) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        env_clear();
      end
    end
    drain_idle("rand_idle");

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule

// File: doc/fifo_drain_checker.md
FIFO_DRAIN_CHECKER -- requirements
Module: fifo_drain_checker

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of word/error/request counters.
REQ-002 SHALL have parameter DATA_SEED, default 16'h0001, first expected data word.
REQ-003 SHALL have parameter THR_SEED, default 16'h70f0, throttle LFSR seed.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous clear, active high.
REQ-007 SHALL have port enable  input  1  permits a run to start/continue.
REQ-008 SHALL have port throttle_en  input  1  1 = gate reads by throttle LFSR; 0 = read every permitted cycle.
REQ-009 SHALL have port target  input  CNT_WIDTH  words per run; 0 = unlimited.
REQ-010 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-011 SHALL have port read_data  input  16  FIFO read data.
REQ-012 SHALL have port rdata_valid  input  1  read_data valid this cycle.
REQ-013 SHALL have port read_req  output  1  read request to FIFO, one word per asserted cycle.
REQ-014 SHALL have ports word_count, err_count  output  CNT_WIDTH each  words received / mismatches.
REQ-015 SHALL have ports mismatch  output  1 (sticky), first_err_data  output  16, first_err_exp  output  16.
REQ-016 SHALL have ports busy, done  output  1 each  run in progress / run complete.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE->RUN when enable=1; RUN->DRAIN when enable=0 or (target!=0 and issued==target); DRAIN->DONE when outstanding==0 and target!=0 and word_count>=target; DRAIN->IDLE when outstanding==0 otherwise; DONE->IDLE when enable=0.
REQ-019 read_req SHALL be combinational: state==RUN and ~fifo_empty and (~throttle_en or thr[7] or thr[13]) and not (target!=0 and issued==target).
REQ-020 Throttle LFSR thr SHALL advance every cycle: thr <= {thr[14:0], ~(thr[15]^thr[14]^thr[12]^thr[3])}.
REQ-021 Expected value exp SHALL advance only on rdata_valid: exp <= {exp[14:0], exp[15]^exp[14]}.
REQ-022 On rdata_valid, read_data SHALL be compared with exp same cycle; word_count+1; on inequality err_count+1.
REQ-023 First mismatch since reset/flush SHALL set mismatch and capture read_data/exp into first_err_data/first_err_exp; later mismatches SHALL not overwrite.
REQ-024 issued SHALL increment per read_req cycle; outstanding = issued - word_count; rdata_valid with outstanding==0 SHALL count as an error (unexpected data) and still advance exp.
REQ-025 Counters SHALL saturate at all-ones, never wrap.
REQ-026 Simultaneous read_req and rdata_valid SHALL update issued and word_count in the same cycle.
REQ-027 busy = state RUN or DRAIN; done = state DONE; both registered-state decoded.
REQ-028 FIFO read latency SHALL not be assumed; any number of outstanding requests tolerated.

Reset
REQ-029 reset_n=0 SHALL immediately force: state IDLE, read_req 0, counters/issued 0, mismatch 0, first_err_* 0, exp=DATA_SEED, thr=THR_SEED, busy 0, done 0.
REQ-030 flush=1 SHALL, at next edge, apply the same values as REQ-029 and take priority over all other updates, including mid-run.

Verification
REQ-031 enable=1, throttle_en=0, target=16, FIFO preloaded with 0x0001<<i (i=0..14) then 0x8001 -> 16 read_req, word_count=16, err_count=0, done=1.
REQ-032 Word 17 expected 0x0003; feed 0x0004 -> err_count=1, mismatch=1, first_err_data=0x0004, first_err_exp=0x0003; second bad word leaves captures unchanged.
REQ-033 fifo_empty=1 throughout RUN -> read_req never asserted, word_count stays 0.
REQ-034 throttle_en=1 after reset -> read_req pattern equals thr[7]|thr[13] from seed 0x70f0 (first cycle permitted).
REQ-035 enable dropped mid-run with 2 outstanding -> DRAIN, read_req=0, returns IDLE after 2 rdata_valid, counts retained.
REQ-036 reset_n pulse mid-run, and separately flush=1 -> all outputs at REQ-029 values; next run restarts expecting 0x0001.
